seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the common-anode 8-digit seven-segment display of the digital clock.
- Takes the packed BCD/glyph codes and decimal points for every digit.
- Each digit slot, it presents one digit's 4-bit code and point flag to the downstream segment decoder (code 15 = blank) and drives the matching active-low anode enable.
- Adds an anti-ghosting blanking gap at the start of each slot and a per-digit blink function for clock-setting mode.

Parameters:
- DIGITS, 8: number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot; must be >= 2.
- BLANK_CYC, 1000: cycles at the start of each slot with all anodes off; must be < SCAN_DIV.
- BLINK_FRAMES, 125: full scan frames per blink half-period; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- en  input  1  scan enable; 0 = display dark, counters frozen
- digits  input  4*DIGITS  digit codes; digit k is bits [4k+3:4k], digit 0 is rightmost
- points  input  DIGITS  decimal point request per digit (1 = lit)
- blink_mask  input  DIGITS  1 = digit k blinks
- num  output  4  code to the segment decoder; 4'hF = blank
- point  output  1  decimal point to the segment decoder
- an  output  DIGITS  anode enables, active-low
- frame_start  output  1  one-cycle pulse at the start of slot 0

Behaviour:
- Reset: one clock, synchronous, active-high (port rst, clock clk). Reset is synchronous and applies at the next rising clk edge, including mid-slot or mid-frame.
- After that reset edge:
  - div_cnt=0, idx=0, frame_cnt=0, blink_phase=0.
  - Snapshot regs: num=4'hF, point=0.
  - an = all ones.
- Slot counter, each clk edge with rst=0, en=1:
  - If div_cnt==SCAN_DIV-1: div_cnt<=0 and idx<=(idx==DIGITS-1)?0:idx+1.
  - Otherwise div_cnt<=div_cnt+1.
- Frame and blink:
  - On the edge where idx wraps DIGITS-1 -> 0: if frame_cnt==BLINK_FRAMES-1, then frame_cnt<=0 and blink_phase toggles; else frame_cnt increments.
- Snapshot load, on the same edge that sets div_cnt to 0:
  - Source: digit new_idx, where new_idx is the updated idx value.
  - If blink_mask[new_idx]=1 and the updated blink_phase=1: num<=4'hF, point<=0.
  - Else: num<=digits[4*new_idx+:4], point<=points[new_idx].
  - num/point are constant for the whole slot. Input changes mid-slot take effect at the next slot boundary for that digit.
  - The very first slot after reset is blank (snapshot reset value).
- Anode decode (combinational from registered state and en):
  - an = all ones when en=0 or div_cnt<BLANK_CYC.
  - Otherwise an = ~(1<<idx), exactly one bit low.
- frame_start = en && idx==0 && div_cnt==0. It is high in the first cycle after reset when en=1.
- en=0:
  - div_cnt, idx, frame_cnt, blink_phase and the snapshot hold their values.
  - an is all ones in that same cycle.
  - When en returns to 1, counting resumes from the held state and no slot restarts.
- Codes 10..14 pass through unchanged; the decoder renders them as H/E/L/O/blank.
- Scan and blink use no arithmetic beyond the counters. Counter widths: $clog2(SCAN_DIV), $clog2(DIGITS) (min 1), $clog2(BLINK_FRAMES) (min 1).
- No other outputs are registered beyond the snapshot. an and frame_start are decodes of flops and must be glitch-free at the flop level: no input-to-output paths except en.

Test Plan (DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2 unless noted):
- Reset, en=1, digits=16'h4321, points=0, blink_mask=0:
  - cycles 0-3: num=F, an=1111 at cycle 0, 1110 at cycles 1-3.
  - cycle 4: num=2, an=1111.
  - cycles 5-7: an=1101.
  - cycle 8: num=3.
  - frame_start high at cycles 0 and 16 only.
- Change digits from 16'h4321 to 16'h9999 at cycle 5, during slot 1:
  - num stays 2 through cycle 7.
  - slot 2 shows 9.
- points=4'b0100: point=1 only during slot 2 (cycles 8-11); 0 elsewhere.
- blink_mask=4'b0001, digits=16'h4321:
  - frames 0-1: digit 0 shows 1 (frame 0's slot 0 is the reset blank).
  - frames 2-3: digit 0 shows F with an still strobing.
  - other digits unaffected.
  - frames 4-5: visible again.
- en=0 at cycle 6 for 5 cycles:
  - an=1111 and num/idx/div_cnt frozen during cycles 6-10.
  - at cycle 11, an=1101 and div_cnt resumes at 2; slot 1 ends at cycle 12.
- rst pulse at cycle 10, mid-slot 2:
  - next cycle: div_cnt=0, idx=0, num=F, frame_start=1, blink_phase=0.
  - full sequence replays as in scenario 1.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit seven-segment display.
// Presents one digit code per slot to the segment decoder, with an anti-ghosting gap and per-digit blink.
module seg_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     points,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [3:0]            num,
    output logic                  point,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] BLANK_END  = DW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [3:0]    CODE_BLANK = 4'hF;

    logic [DW-1:0] div_cnt;
    logic [IW-1:0] idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    logic          slot_end;
    logic          frame_end;
    logic [IW-1:0] next_idx;
    logic          next_phase;

    // Look-ahead values so the snapshot for the new slot is taken on the same edge the slot begins.
    always_comb begin
        slot_end   = (div_cnt == DIV_LAST);
        frame_end  = slot_end && (idx == IDX_LAST);
        next_idx   = frame_end ? '0 : idx + 1'b1;
        next_phase = (frame_end && (frame_cnt == FRAME_LAST)) ? ~blink_phase : blink_phase;
    end

    // NOTE: all state is assigned with <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            num         <= CODE_BLANK;
            point       <= 1'b0;
        end else if (en) begin
            if (slot_end) begin
                div_cnt <= '0;
                idx     <= next_idx;
                if (frame_end) begin
                    frame_cnt   <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
                    blink_phase <= next_phase;
                end
                if (blink_mask[next_idx] && next_phase) begin
                    num   <= CODE_BLANK;
                    point <= 1'b0;
                end else begin
                    num   <= digits[4*next_idx +: 4];
                    point <= points[next_idx];
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latches).
    always_comb begin
        an          = '1;
        frame_start = en && (idx == '0) && (div_cnt == '0);
        if (en && (div_cnt >= BLANK_END)) begin
            an[idx] = 1'b0;
        end
    end

endmodule
